// File: rtl/sketch_ram_pkg.sv
// Shared definitions for the sketch RAM: port B opcodes, init FSM states and the
// saturating-add helper used by the read-modify-write path.
package sketch_ram_pkg;

  // Largest supported read latency in cycles.
  localparam int unsigned RdLatMax = 8;

  typedef enum logic [1:0] {
    OpRead  = 2'd0,
    OpWrite = 2'd1,
    OpAdd   = 2'd2,
    OpNop   = 2'd3
  } b_op_e;

  typedef enum logic [0:0] {
    StSweep = 1'b0,
    StReady = 1'b1
  } init_state_e;

  // Unsigned a+b clamped to 2**w-1; callers truncate the result to w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/ram_delay_line.sv
// Valid+data shift register that pads a response path to a fixed latency.
// Data is zeroed whenever valid is low so the output reads 0 between responses.
module ram_delay_line #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_valid ? in_data : '0;
  end else begin : g_pipe
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        for (int i = 0; i < STAGES; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        valid_q[0] <= in_valid;
        data_q[0]  <= in_valid ? in_data : '0;
        for (int i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/param_sketch_ram.sv
// Dual-port counter RAM: port A reads, port B reads/writes/saturating-adds with a
// two-stage read-modify-write pipeline, write forwarding and a clear sweep.
module param_sketch_ram
  import sketch_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 2140,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              init_done,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic [1:0]        b_op,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_ready,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid
);

  localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LatEff    = (RD_LAT < 1) ? 1 : ((RD_LAT > RdLatMax) ? RdLatMax : RD_LAT);
  localparam int unsigned PadStages = LatEff - 1;
  localparam logic [IdxW-1:0] SweepLast = IdxW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  init_state_e     state_q, state_d;
  logic [IdxW-1:0] sweep_q, sweep_d;

  logic        mem_we;
  logic [IdxW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  b_op_e           b_op_in;
  logic            a_acc, b_acc;
  logic            a_in_range, b_in_range;
  logic [IdxW-1:0] a_idx, b_idx;
  logic            a_fwd_hit, b_fwd_hit;

  // Stage-1 registers: request captured alongside the synchronous memory read.
  logic              a_s1_vld_q, a_s1_inr_q, a_s1_fwd_q;
  logic              b_s1_vld_q, b_s1_inr_q, b_s1_fwd_q;
  b_op_e             b_s1_op_q;
  logic [ADDR_W-1:0] b_s1_addr_q;
  logic [DATA_W-1:0] b_s1_din_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] a_rd_q, b_rd_q;

  logic [DATA_W-1:0] a_old, b_old, b_sum, b_new;
  logic [DATA_W-1:0] a_s2_data, b_s2_data;
  logic              commit;

  assign init_done = (state_q == StReady);
  assign b_ready   = init_done;
  assign b_op_in   = b_op_e'(b_op);

  // A request coinciding with clr is refused so nothing new enters the sweep.
  assign a_acc = a_en & init_done & ~clr;
  assign b_acc = b_en & init_done & ~clr & (b_op_in != OpNop);

  assign a_in_range = (32'(a_addr) < DEPTH);
  assign b_in_range = (32'(b_addr) < DEPTH);
  assign a_idx      = a_in_range ? a_addr[IdxW-1:0] : '0;
  assign b_idx      = b_in_range ? b_addr[IdxW-1:0] : '0;

  // Stage 2: resolve forwarded data and compute the new value.
  assign a_old = a_s1_fwd_q ? fwd_data_q : a_rd_q;
  assign b_old = b_s1_fwd_q ? fwd_data_q : b_rd_q;
  assign b_sum = DATA_W'(sat_add(32'(b_old), 32'(b_s1_din_q), DATA_W));

  always_comb begin
    b_new = b_old;
    unique case (b_s1_op_q)
      OpWrite: b_new = b_s1_din_q;
      OpAdd:   b_new = b_sum;
      default: b_new = b_old;
    endcase
  end

  assign commit = b_s1_vld_q & b_s1_inr_q & ((b_s1_op_q == OpWrite) | (b_s1_op_q == OpAdd));

  // The memory read this cycle misses the commit landing at the same edge, so forward it.
  assign a_fwd_hit = commit & (a_addr == b_s1_addr_q);
  assign b_fwd_hit = commit & (b_addr == b_s1_addr_q);

  assign a_s2_data = a_s1_inr_q ? a_old : '0;
  assign b_s2_data = !b_s1_inr_q ? '0 : ((b_s1_op_q == OpRead) ? b_old : b_new);

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    mem_we    = 1'b0;
    mem_waddr = b_s1_addr_q[IdxW-1:0];
    mem_wdata = b_new;
    unique case (state_q)
      StSweep: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        if (sweep_q == SweepLast) begin
          state_d = StReady;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      StReady: begin
        mem_we = commit;
        if (clr) begin
          state_d = StSweep;
          sweep_d = '0;
        end
      end
      default: state_d = StSweep;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSweep;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_vld_q  <= 1'b0;
      a_s1_inr_q  <= 1'b0;
      a_s1_fwd_q  <= 1'b0;
      b_s1_vld_q  <= 1'b0;
      b_s1_inr_q  <= 1'b0;
      b_s1_fwd_q  <= 1'b0;
      b_s1_op_q   <= OpRead;
      b_s1_addr_q <= '0;
      b_s1_din_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      a_s1_vld_q  <= a_acc;
      a_s1_inr_q  <= a_in_range;
      a_s1_fwd_q  <= a_fwd_hit;
      b_s1_vld_q  <= b_acc;
      b_s1_inr_q  <= b_in_range;
      b_s1_fwd_q  <= b_fwd_hit;
      b_s1_op_q   <= b_op_in;
      b_s1_addr_q <= b_addr;
      b_s1_din_q  <= b_din;
      fwd_data_q  <= b_new;
    end
  end

  // Array is deliberately not reset; the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (a_acc) begin
      a_rd_q <= mem[a_idx];
    end
    if (b_acc) begin
      b_rd_q <= mem[b_idx];
    end
  end

  ram_delay_line #(
    .WIDTH  (DATA_W),
    .STAGES (PadStages)
  ) u_a_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_s1_vld_q),
    .in_data   (a_s2_data),
    .out_valid (a_valid),
    .out_data  (a_dout)
  );

  ram_delay_line #(
    .WIDTH  (DATA_W),
    .STAGES (PadStages)
  ) u_b_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_s1_vld_q),
    .in_data   (b_s2_data),
    .out_valid (b_valid),
    .out_data  (b_dout)
  );

endmodule

// File: tb/tb_param_sketch_ram.sv
// Directed bench for param_sketch_ram with DEPTH=16, DATA_W=4, RD_LAT=3; responses are
// captured with their cycle number and compared against hand-computed values.
module tb_param_sketch_ram;
  import sketch_ram_pkg::*;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned LAT   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          init_done;
  logic          a_en = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_dout;
  logic          a_valid;
  logic          b_en = 1'b0;
  logic [1:0]    b_op = '0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din = '0;
  logic          b_ready;
  logic [DW-1:0] b_dout;
  logic          b_valid;

  param_sketch_ram #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .RD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .init_done (init_done),
    .a_en      (a_en),
    .a_addr    (a_addr),
    .a_dout    (a_dout),
    .a_valid   (a_valid),
    .b_en      (b_en),
    .b_op      (b_op),
    .b_addr    (b_addr),
    .b_din     (b_din),
    .b_ready   (b_ready),
    .b_dout    (b_dout),
    .b_valid   (b_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int data;
  } resp_t;

  resp_t a_q[$];
  resp_t b_q[$];
  int    cyc = 0;
  int    dirty = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_valid) a_q.push_back('{cyc: cyc, data: int'(a_dout)});
    else if (a_dout != '0) dirty++;
    if (b_valid) b_q.push_back('{cyc: cyc, data: int'(b_dout)});
    else if (b_dout != '0) dirty++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    a_en = 1'b0;
    b_en = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic a_issue(input int addr);
    a_en   = 1'b1;
    a_addr = AW'(addr);
  endtask

  task automatic b_issue(input b_op_e op, input int addr, input int din);
    b_en   = 1'b1;
    b_op   = op;
    b_addr = AW'(addr);
    b_din  = DW'(din);
  endtask

  task automatic flush();
    a_q.delete();
    b_q.delete();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      n++;
      step(1);
    end
  endtask

  task automatic chk_resp(input string tag, input bit port_b, input int idx, input int exp_cyc,
                          input int exp_data);
    int    n;
    resp_t r;
    n = port_b ? b_q.size() : a_q.size();
    if (idx < n) begin
      r = port_b ? b_q[idx] : a_q[idx];
      check({tag, "_data"}, r.data, exp_data);
      check({tag, "_cyc"}, r.cyc, exp_cyc);
    end else begin
      check({tag, "_missing"}, n, idx + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int ta;
    int n;

    // Reset state and initial sweep.
    idle();
    step(3);
    check("rst_init_done", int'(init_done), 0);
    check("rst_b_ready", int'(b_ready), 0);
    check("rst_a_valid", int'(a_valid), 0);
    check("rst_b_valid", int'(b_valid), 0);
    check("rst_a_dout", int'(a_dout), 0);
    check("rst_b_dout", int'(b_dout), 0);
    rst_n = 1'b1;
    wait_init(n);
    check("init_cycles", n, 16);
    check("b_ready_up", int'(b_ready), 1);

    // Every word reads back as zero after the sweep.
    flush();
    t = cyc;
    b_issue(OpRead, 15, 0);
    for (int i = 0; i < 16; i++) begin
      a_issue(i);
      step(1);
      b_en = 1'b0;
    end
    idle();
    step(LAT + 2);
    check("rd0_a_cnt", a_q.size(), 16);
    for (int i = 0; i < 16; i++) chk_resp($sformatf("rd0_a%0d", i), 1'b0, i, t + i + LAT, 0);
    check("rd0_b_cnt", b_q.size(), 1);
    chk_resp("rd0_b", 1'b1, 0, t + LAT, 0);

    // Write then read of the same word while the write is committing.
    flush();
    t = cyc;
    b_issue(OpWrite, 5, 9);
    step(1);
    idle();
    a_issue(5);
    step(1);
    idle();
    step(LAT + 2);
    check("wr5_b_cnt", b_q.size(), 1);
    check("wr5_a_cnt", a_q.size(), 1);
    chk_resp("wr5_b", 1'b1, 0, t + LAT, 9);
    chk_resp("wr5_a", 1'b0, 0, t + 1 + LAT, 9);

    // Back-to-back adds accumulate.
    flush();
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      b_issue(OpAdd, 3, 1);
      step(1);
    end
    idle();
    step(1);
    ta = cyc;
    a_issue(3);
    step(1);
    idle();
    step(LAT + 2);
    check("add3_b_cnt", b_q.size(), 3);
    for (int k = 0; k < 3; k++) chk_resp($sformatf("add3_b%0d", k), 1'b1, k, t + k + LAT, k + 1);
    chk_resp("add3_a", 1'b0, 0, ta + LAT, 3);

    // Saturating add.
    flush();
    t = cyc;
    b_issue(OpWrite, 7, 14);
    step(1);
    b_issue(OpAdd, 7, 5);
    step(1);
    idle();
    step(LAT + 2);
    check("sat_b_cnt", b_q.size(), 2);
    chk_resp("sat_wr", 1'b1, 0, t + LAT, 14);
    chk_resp("sat_add", 1'b1, 1, t + 1 + LAT, 15);

    // Out-of-range address: write discarded, responses return zero.
    flush();
    t = cyc;
    b_issue(OpWrite, 20, 6);
    step(1);
    idle();
    a_issue(20);
    step(1);
    idle();
    a_issue(4);
    b_issue(OpRead, 5, 0);
    step(1);
    idle();
    step(LAT + 2);
    check("oor_b_cnt", b_q.size(), 2);
    check("oor_a_cnt", a_q.size(), 2);
    chk_resp("oor_b_wr", 1'b1, 0, t + LAT, 0);
    chk_resp("oor_b_rd5", 1'b1, 1, t + 2 + LAT, 9);
    chk_resp("oor_a_rd20", 1'b0, 0, t + 1 + LAT, 0);
    chk_resp("oor_a_rd4", 1'b0, 1, t + 2 + LAT, 0);

    // Reserved opcode: no response, no change.
    flush();
    b_issue(OpNop, 5, 2);
    step(1);
    idle();
    step(LAT + 2);
    check("nop_b_cnt", b_q.size(), 0);
    t = cyc;
    a_issue(5);
    step(1);
    idle();
    step(LAT + 2);
    chk_resp("nop_a_rd5", 1'b0, 0, t + LAT, 9);

    // Clear sweep: in-flight write completes, requests during the sweep are dropped.
    flush();
    t = cyc;
    b_issue(OpWrite, 2, 10);
    step(1);
    idle();
    clr = 1'b1;
    step(1);
    idle();
    check("clr_init_low", int'(init_done), 0);
    check("clr_b_ready", int'(b_ready), 0);
    a_issue(5);
    b_issue(OpRead, 7, 0);
    wait_init(n);
    idle();
    check("clr_cycles", n, 16);
    step(LAT + 2);
    check("clr_b_cnt", b_q.size(), 1);
    chk_resp("clr_wr", 1'b1, 0, t + LAT, 10);
    check("clr_a_cnt", a_q.size(), 0);
    flush();
    t = cyc;
    a_issue(2);
    step(1);
    a_issue(5);
    step(1);
    a_issue(7);
    step(1);
    a_issue(3);
    step(1);
    idle();
    step(LAT + 2);
    check("clr_rd_cnt", a_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_resp($sformatf("clr_rd%0d", i), 1'b0, i, t + i + LAT, 0);

    // Reset mid-operation and mid-sweep.
    b_issue(OpWrite, 6, 11);
    step(1);
    idle();
    step(LAT + 2);
    flush();
    a_issue(6);
    step(1);
    idle();
    step(1);
    b_issue(OpAdd, 1, 2);
    step(1);
    idle();
    #2;
    check("pre_rst_a_valid", int'(a_valid), 1);
    check("pre_rst_a_dout", int'(a_dout), 11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a_valid", int'(a_valid), 0);
    check("mid_rst_a_dout", int'(a_dout), 0);
    check("mid_rst_b_valid", int'(b_valid), 0);
    check("mid_rst_init", int'(init_done), 0);
    check("mid_rst_b_ready", int'(b_ready), 0);
    flush();
    step(2);
    rst_n = 1'b1;
    step(5);
    rst_n = 1'b0;
    #1;
    check("sweep_rst_init", int'(init_done), 0);
    step(1);
    rst_n = 1'b1;
    wait_init(n);
    check("restart_cycles", n, 16);
    check("spurious_a", a_q.size(), 0);
    check("spurious_b", b_q.size(), 0);
    t = cyc;
    a_issue(1);
    step(1);
    a_issue(6);
    step(1);
    idle();
    step(LAT + 2);
    check("post_rst_cnt", a_q.size(), 2);
    chk_resp("post_rst_rd1", 1'b0, 0, t + LAT, 0);
    chk_resp("post_rst_rd6", 1'b0, 1, t + 1 + LAT, 0);

    check("idle_dout_zero", dirty, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_sketch_ram.md
PARAM_SKETCH_RAM -- requirements
Module: param_sketch_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 4, counter/data word width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 2140, number of words (2..65536).
REQ-003 SHALL have parameter ADDR_W, default 12, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 3, read latency in cycles (1..8).
REQ-005 SHALL have ports (name direction width meaning):
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  one-cycle pulse that starts a memory clear sweep.
- init_done  out  1  high when the memory is cleared and ready.
- a_en  in  1  port A read request.
- a_addr  in  ADDR_W  port A address.
- a_dout  out  DATA_W  port A read data.
- a_valid  out  1  port A data valid.
- b_en  in  1  port B request.
- b_op  in  2  port B operation: 0 = READ, 1 = WRITE, 2 = ADD (saturating), 3 = reserved (no-op).
- b_addr  in  ADDR_W  port B address.
- b_din  in  DATA_W  write data or increment.
- b_ready  out  1  port B can accept a request.
- b_dout  out  DATA_W  port B result.
- b_valid  out  1  port B result valid.

Function
REQ-006 SHALL accept an A request when a_en=1 and init_done=1; a request at any other time is dropped with no response.
REQ-007 SHALL accept a B request when b_en=1 and b_ready=1; b_ready SHALL equal init_done.
REQ-008 SHALL make both ports fully pipelined: one request per port per cycle, in-order responses.
REQ-009 SHALL, for an accepted read on either port in cycle t, assert valid for exactly one cycle at t+RD_LAT with the data; at all other times valid=0 and dout=0.
REQ-010 SHALL commit WRITE and ADD to memory at the end of cycle t+1, using a 2-stage pipeline: read/capture in stage 1, compute/write in stage 2.
REQ-011 SHALL compute ADD as old+b_din, saturating at 2**DATA_W-1 with no wrap.
REQ-012 SHALL return the post-update value on b_dout for WRITE and ADD at t+RD_LAT, with b_valid=1.
REQ-013 SHALL forward pending stage-2 write data to any stage-1 read of the same address, on either port; back-to-back ADDs to one address SHALL accumulate exactly.
REQ-014 SHALL, for a read on port A in the same cycle as a B commit to the same address, return the committed (new) value via forwarding.
REQ-015 SHALL treat b_op=3 as a no-op that is accepted but produces no response.
REQ-016 SHALL treat an address >= DEPTH as follows: a read returns 0 with valid asserted; a write or add is discarded, and the response is still returned with value 0.
REQ-017 SHALL clear the memory with a sweep counter (one word per cycle, 0..DEPTH-1), holding init_done=0 for DEPTH cycles; init_done SHALL rise the cycle after the last word is written.
REQ-018 SHALL ignore clr while a sweep is in progress.
REQ-019 SHALL complete responses already in the pipeline when clr is asserted; no new requests SHALL be accepted once clr is asserted.

Reset
REQ-020 SHALL, on rst_n=0, asynchronously force a_valid=0, b_valid=0, a_dout=0, b_dout=0, init_done=0, b_ready=0, flush all pipeline stages, and zero the sweep counter.
REQ-021 SHALL start a clear sweep automatically on rst_n release; reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0.
REQ-022 SHALL NOT reset the memory array itself; clearing is done by the sweep.

Structure
REQ-023 SHALL place the b_op encodings, the saturation helper function and the RD_LAT bound constant in a shared package, sketch_ram_pkg.
REQ-024 SHALL instantiate one sub-module, ram_delay_line (parametrised width/depth valid+data shift register), to pad each port to RD_LAT.

Verification
REQ-025 SHALL cover: reset release, DEPTH=16 -> init_done=0 for 16 cycles then 1; all reads return 0.
REQ-026 SHALL cover: WRITE addr 5 data 9, then A read addr 5 at t+1 -> a_valid at t+1+RD_LAT with a_dout=9.
REQ-027 SHALL cover: ADD addr 3 inc 1 on three consecutive cycles, DATA_W=4 -> b_dout responses 1, 2, 3; a subsequent read gives 3.
REQ-028 SHALL cover: WRITE addr 7 data 14, then ADD inc 5 -> b_dout=15 (saturated).
REQ-029 SHALL cover: clr pulse after writes -> init_done drops, b_ready=0 for DEPTH cycles, then reads return 0.
REQ-030 SHALL cover: rst_n asserted mid-sweep and mid-ADD -> outputs zero immediately, the sweep restarts, and no spurious valid appears.
